// File: rtl/bram_flush_pkg.sv
// Shared types and width helpers for the BRAM flush controller.
package bram_flush_pkg;

  typedef enum logic [1:0] {RST_WAIT, IDLE, FLUSH, DONE} flush_state_t;

  // One extra counter bit lets a full-depth sweep reach DEPTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned CNT_W      = cnt_width(ADDR_W_DEF);

endpackage

// File: rtl/bram_flush_addr_cnt.sv
// Flush sweep address counter: clear, load, increment, terminal count at DEPTH-1.
module bram_flush_addr_cnt
  import bram_flush_pkg::*;
#(
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              tc_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign addr = cnt[ADDR_W-1:0];
  assign tc_c = (cnt == CNT_W'(DEPTH - 1));

endmodule

// File: rtl/bram_flush_ctrl.sv
// BRAM flush sequencer and user/flush port arbiter with registered BRAM port.
module bram_flush_ctrl
  import bram_flush_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 10,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 1024,
  parameter logic [DATA_W-1:0] FLUSH_VAL      = '0,
  parameter bit                FLUSH_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  input  logic              user_req,
  input  logic              user_we,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [DATA_W-1:0] user_wdata,
  output logic              user_gnt,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata
);

  localparam int unsigned CW = cnt_width(ADDR_W);

  flush_state_t      state, state_next;
  logic              en_d, we_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              cnt_clr, cnt_load, cnt_en, cnt_tc;
  logic [ADDR_W-1:0] cnt_addr;

  bram_flush_addr_cnt #(
    .CNT_W  (CW),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (CW'(0)),
    .en       (cnt_en),
    .addr     (cnt_addr),
    .tc_c     (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FLUSH_ON_RESET ? RST_WAIT : IDLE;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      bram_en    <= en_d;
      bram_we    <= we_d;
      bram_addr  <= addr_d;
      bram_wdata <= wdata_d;
      flush_busy <= busy_d;
      flush_done <= done_d;
    end
  end

  // Next state, arbitration and the values the output registers take next.
  always_comb begin
    state_next = state;
    user_gnt   = 1'b0;
    en_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = bram_addr;
    wdata_d    = bram_wdata;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      RST_WAIT: begin
        state_next = FLUSH;
        cnt_load   = 1'b1;
      end
      IDLE: begin
        if (flush_req) begin
          state_next = FLUSH;
          cnt_load   = 1'b1;
        end else begin
          user_gnt = user_req;
          if (user_req) begin
            en_d    = 1'b1;
            we_d    = user_we;
            addr_d  = user_addr;
            wdata_d = user_wdata;
          end
        end
      end
      FLUSH: begin
        busy_d  = 1'b1;
        en_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = cnt_addr;
        wdata_d = FLUSH_VAL;
        cnt_en  = 1'b1;
        if (cnt_tc) state_next = DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        cnt_clr    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_flush_ctrl.sv
// Randomized scoreboard bench for bram_flush_ctrl (ADDR_W=3, DEPTH=8, flush on reset).
module tb_bram_flush_ctrl;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush_req = 1'b0;
  logic              flush_busy, flush_done;
  logic              user_req = 1'b0;
  logic              user_we = 1'b0;
  logic [ADDR_W-1:0] user_addr = '0;
  logic [DATA_W-1:0] user_wdata = '0;
  logic              user_gnt;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;

  bram_flush_ctrl #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .FLUSH_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .user_req   (user_req),
    .user_we    (user_we),
    .user_addr  (user_addr),
    .user_wdata (user_wdata),
    .user_gnt   (user_gnt),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a list of flush writes still owed, plus a pending done pulse.
  int                pend[$];
  bit                done_pend = 1'b0;
  bit                rst_wait  = 1'b0;
  logic [ADDR_W-1:0] last_addr  = '0;
  logic [DATA_W-1:0] last_wdata = '0;
  exp_t              expq[$];

  task automatic start_flush();
    for (int i = 0; i < int'(DEPTH); i++) pend.push_back(i);
    done_pend = 1'b1;
  endtask

  task automatic step(input logic r, input logic fr, input logic ur, input logic uwe,
                      input logic [ADDR_W-1:0] ua, input logic [DATA_W-1:0] ud);
    exp_t e;
    logic g;
    @(negedge clk);
    rst_n = r; flush_req = fr; user_req = ur; user_we = uwe;
    user_addr = ua; user_wdata = ud;
    #1;
    g = 1'b0;
    e = '0;
    e.addr  = last_addr;
    e.wdata = last_wdata;
    if (!r) begin
      pend.delete();
      done_pend = 1'b0;
      rst_wait  = 1'b1;
      e = '0;
    end else begin
      if (rst_wait) begin
        rst_wait = 1'b0;
        start_flush();
      end else if (pend.size() > 0) begin
        e.en    = 1'b1;
        e.we    = 1'b1;
        e.addr  = ADDR_W'(pend.pop_front());
        e.wdata = '0;
        e.busy  = 1'b1;
      end else if (done_pend) begin
        done_pend = 1'b0;
        e.done    = 1'b1;
      end else if (fr) begin
        start_flush();
      end else begin
        g = ur;
        if (ur) begin
          e.en    = 1'b1;
          e.we    = uwe;
          e.addr  = ua;
          e.wdata = ud;
        end
      end
      n_checks++;
      if (user_gnt === g) n_pass++;
      else $display("FAIL user_gnt at %0t: got %b expected %b", $time, user_gnt, g);
    end
    last_addr  = e.addr;
    last_wdata = e.wdata;
    expq.push_back(e);
  endtask

  task automatic rnd_step(input logic r, input logic fr);
    step(r, fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         ADDR_W'($urandom), DATA_W'($urandom));
  endtask

  // Monitor: compares the registered BRAM port against the oldest expectation.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        got = {bram_en, bram_we, bram_addr, bram_wdata, flush_busy, flush_done};
        n_checks++;
        if (got === e) n_pass++;
        else $display("FAIL bram_port at %0t: got en=%b we=%b addr=%0h wdata=%h busy=%b done=%b expected en=%b we=%b addr=%0h wdata=%h busy=%b done=%b",
                      $time, got.en, got.we, got.addr, got.wdata, got.busy, got.done,
                      e.en, e.we, e.addr, e.wdata, e.busy, e.done);
      end
    end
  end

  initial begin
    // Reset, then the automatic flush with user traffic that must not be granted.
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (14) rnd_step(1'b1, 1'b0);
    // Directed user write in IDLE.
    step(1'b1, 1'b0, 1'b1, 1'b1, ADDR_W'(5), 32'hDEADBEEF);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    // Flush and user request together; user keeps asking through the sweep.
    step(1'b1, 1'b1, 1'b1, 1'b1, ADDR_W'(2), 32'h12345678);
    repeat (12) step(1'b1, 1'b0, 1'b1, 1'b1, ADDR_W'(2), 32'h12345678);
    // flush_req held across two full sweeps.
    repeat (24) rnd_step(1'b1, 1'b1);
    repeat (12) rnd_step(1'b1, 1'b0);
    // Reset once the sweep has issued address 3.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    repeat (4) rnd_step(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (14) rnd_step(1'b1, 1'b0);
    // Random mix with occasional flush requests and resets.
    for (int i = 0; i < 300; i++) begin
      rnd_step(($urandom_range(0, 149) != 0), ($urandom_range(0, 19) == 0));
    end
    repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
